log2_approx_pipe: RTL

Pipelined, parametrised Mitchell-style log2 approximator with valid/ready streaming handshake, an optional piecewise-linear error-correction mode, and explicit zero-input handling. It sits in the softmax/approximation datapath between the fixed-point exponent/normaliser stages and downstream log-domain arithmetic. It replaces the single-cycle combinational 16-bit Q4.12 log2 block. It widens the integer field so negative results no longer wrap, and carries a sideband tag so several channels can share one instance.

---
 rtl/log2_approx_pipe.sv | 105 ++++++++++
 1 files changed

// File: rtl/log2_approx_pipe.sv
// log2_approx_pipe: 3-stage Mitchell log2 approximator (LOD, normalise, correct) with
// valid/ready flow control, optional piecewise-linear correction and zero-input flagging.
module log2_approx_pipe #(
  parameter int IN_W     = 16,
  parameter int IN_FRAC  = 12,
  parameter int OUT_INT  = 5,
  parameter int OUT_FRAC = 12,
  parameter int TAG_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_W-1:0]             in_x,
  input  logic [TAG_W-1:0]            in_tag,
  input  logic                        corr_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_INT+OUT_FRAC-1:0] out_log2,
  output logic                        out_zero,
  output logic [TAG_W-1:0]            out_tag
);
  localparam int PW    = $clog2(IN_W);
  localparam int FW    = OUT_FRAC + 1;
  localparam int OUT_W = OUT_INT + OUT_FRAC;
  logic                advance;
  logic                s1_v_q, s1_zero_q, s1_corr_q;
  logic [IN_W-1:0]     s1_x_q;
  logic [TAG_W-1:0]    s1_tag_q;
  logic [PW-1:0]       s1_p_q, s1_p_d;
  logic                s2_v_q, s2_zero_q, s2_corr_q;
  logic [TAG_W-1:0]    s2_tag_q;
  logic [OUT_INT-1:0]  s2_int_q, s2_int_d;
  logic [OUT_FRAC-1:0] s2_f_q, s2_f_d;
  logic [PW-1:0]       sh;
  logic [FW-1:0]       f_ext, f_cmp, m, corr;
  logic [OUT_FRAC-1:0] frac;
  logic                out_valid_q, out_zero_q;
  logic [OUT_W-1:0]    out_log2_q, out_log2_d;
  logic [TAG_W-1:0]    out_tag_q;

  assign advance  = ~out_valid_q | out_ready;
  assign in_ready = advance;

  always_comb begin
    s1_p_d = '0;
    for (int i = 0; i < IN_W; i++) if (in_x[i]) s1_p_d = PW'(i);
  end

  // Left-align the leading one at the top of a frac-padded word; the bits beneath it are f.
  assign sh       = PW'(IN_W - 1) - s1_p_q;
  assign s2_int_d = OUT_INT'(int'({1'b0, s1_p_q}) - IN_FRAC);
  assign s2_f_d   = OUT_FRAC'(({s1_x_q, {OUT_FRAC{1'b0}}} << sh) >> (IN_W - 1));

  // m <= half-scale, so corr stays below 2^OUT_FRAC - f and frac never carries into int.
  assign f_ext      = {1'b0, s2_f_q};
  assign f_cmp      = FW'(1 << OUT_FRAC) - f_ext;
  assign m          = (f_ext <= f_cmp) ? f_ext : f_cmp;
  assign corr       = s2_corr_q ? (m >> 3) + (m >> 4) : '0;
  assign frac       = OUT_FRAC'(f_ext + corr);
  assign out_log2_d = s2_zero_q ? {1'b1, {(OUT_W-1){1'b0}}} : {s2_int_q, frac};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_corr_q   <= 1'b0;
      s1_x_q      <= '0;
      s1_tag_q    <= '0;
      s1_p_q      <= '0;
      s2_v_q      <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_corr_q   <= 1'b0;
      s2_tag_q    <= '0;
      s2_int_q    <= '0;
      s2_f_q      <= '0;
      out_valid_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_log2_q  <= '0;
      out_tag_q   <= '0;
    end else if (advance) begin
      s1_v_q      <= in_valid;
      s1_zero_q   <= (in_x == '0);
      s1_corr_q   <= corr_en;
      s1_x_q      <= in_x;
      s1_tag_q    <= in_tag;
      s1_p_q      <= s1_p_d;
      s2_v_q      <= s1_v_q;
      s2_zero_q   <= s1_zero_q;
      s2_corr_q   <= s1_corr_q;
      s2_tag_q    <= s1_tag_q;
      s2_int_q    <= s2_int_d;
      s2_f_q      <= s2_f_d;
      out_valid_q <= s2_v_q;
      out_zero_q  <= s2_zero_q;
      out_log2_q  <= out_log2_d;
      out_tag_q   <= s2_tag_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_log2  = out_log2_q;
  assign out_zero  = out_zero_q;
  assign out_tag   = out_tag_q;
endmodule
